window_collector: RTL and testbench
===================================

WINDOW_COLLECTOR -- requirements
Module: window_collector

Interface
REQ-001 SHALL have parameter DATA_COUNT, default 16: samples per window; power of two, >=2.
REQ-002 SHALL have parameter DATA_WIDTH, default 12: bits per sample.
REQ-003 SHALL have parameter STRIDE, default 1: new samples between consecutive windows once full; range 1..DATA_COUNT.
REQ-004 SHALL have port clock50MHz, input, 1, the single clock; one clock; all state on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port sample_valid, input, 1, sample_data holds a sample.
REQ-007 SHALL have port sample_data, input, DATA_WIDTH, unsigned sample.
REQ-008 SHALL have port sample_ready, output, 1, collector accepts a sample this cycle.
REQ-009 SHALL have port flush, input, 1, discard window contents and restart filling.
REQ-010 SHALL have port window_valid, output, 1, window_data holds a complete window.
REQ-011 SHALL have port window_ready, input, 1, downstream sorter stage takes the window.
REQ-012 SHALL have port window_data, output, DATA_COUNT*DATA_WIDTH, packed window; newest sample in bits [DATA_WIDTH-1:0], oldest in the top slice.
REQ-013 SHALL have port fill_count, output, $clog2(DATA_COUNT+1), samples held, saturating at DATA_COUNT.

Function
REQ-014 SHALL define accept as sample_valid && sample_ready at a rising edge; only an accept modifies the buffer.
REQ-015 SHALL drive sample_ready = !flush && !(window_valid && !window_ready), combinationally.
REQ-016 SHALL, on accept, shift the buffer up one slice, drop the oldest slice, and load sample_data into slice 0.
REQ-017 SHALL drive window_data directly from the buffer register, with no extra pipeline stage.
REQ-018 SHALL have two states: FILL while fill_count < DATA_COUNT, and STREAM once fill_count == DATA_COUNT.
REQ-019 SHALL, in FILL, increment fill_count per accept; the accept reaching DATA_COUNT moves to STREAM, clears the stride counter and triggers a window.
REQ-020 SHALL, in STREAM, count accepts in the stride counter; the accept where the counter equals STRIDE-1 triggers a window and clears the counter, other accepts increment it.
REQ-021 SHALL set window_valid at the edge of a triggering accept, so data and valid appear together one cycle after the accepting edge.
REQ-022 SHALL hold window_valid high and window_data stable until an edge with window_ready high.
REQ-023 SHALL, when a transfer and a triggering accept share an edge, keep window_valid at 1 with the new window; a transfer alone clears window_valid.
REQ-024 SHALL ignore window_ready while window_valid is 0.
REQ-025 SHALL, on flush at an edge, zero the buffer, fill_count, stride counter and window_valid, and return to FILL; the same-edge sample is not accepted.
REQ-026 SHALL give flush precedence over accept and transfer.
REQ-027 SHALL never let fill_count exceed DATA_COUNT; the stride counter width is $clog2(STRIDE+1).

Reset
REQ-028 SHALL, at an edge with reset high, zero the buffer, fill_count, stride counter and window_valid, enter FILL, and override flush and accept.
REQ-029 SHALL make window_data 0, window_valid 0, fill_count 0 after reset; sample_ready is 1 once reset is released and flush is low.
REQ-030 SHALL discard any partial window when reset occurs mid-fill or mid-hold.

Verification (bench: DATA_COUNT=4, DATA_WIDTH=12, STRIDE=2)
REQ-031 SHALL cover: reset held 2 cycles with sample_valid=1 -> no accept, window_valid=0, window_data=0, fill_count=0, then sample_ready=1.
REQ-032 SHALL cover: accept 0x001,0x002,0x003,0x004 back-to-back, window_ready=1 -> window_valid high only in the cycle after the 4th accept, window_data=0x001002003004, fill_count=4.
REQ-033 SHALL cover: continue with 0x005 then 0x006 -> no window after 0x005; window 0x003004005006 after 0x006.
REQ-034 SHALL cover: window_ready=0 for 5 cycles with sample_valid=1, sample 0x007 -> sample_ready=0 and window_data constant for 5 cycles; then window_ready=1 -> transfer and 0x007 accepted that same edge, window_valid then 0.
REQ-035 SHALL cover: flush pulse in STREAM with sample_valid=1 -> fill_count=0, window_valid=0, window_data=0; next window only after 4 fresh accepts.
REQ-036 SHALL cover: window_valid=1 and window_ready=1 on the same edge as the stride-completing accept -> window_valid stays 1 with the updated window_data.

Source files
------------

// File: rtl/window_collector.sv
// Sliding-window sample collector: shifts accepted samples into a DATA_COUNT-deep
// buffer and presents a full window every STRIDE accepts once the buffer has filled.
module window_collector #(
  parameter int DATA_COUNT = 16,
  parameter int DATA_WIDTH = 12,
  parameter int STRIDE     = 1
) (
  input  logic                             clock50MHz,
  input  logic                             reset,
  input  logic                             sample_valid,
  input  logic [DATA_WIDTH-1:0]            sample_data,
  output logic                             sample_ready,
  input  logic                             flush,
  output logic                             window_valid,
  input  logic                             window_ready,
  output logic [DATA_COUNT*DATA_WIDTH-1:0] window_data,
  output logic [$clog2(DATA_COUNT+1)-1:0]  fill_count
);
  localparam int FCW = $clog2(DATA_COUNT+1);
  localparam int SCW = $clog2(STRIDE+1);

  typedef enum logic {FILL, STREAM} state_t;

  state_t                                 state, state_nxt;
  logic [FCW-1:0]                         fill_nxt;
  logic [SCW-1:0]                         stride_cnt, stride_nxt;
  logic                                   valid_nxt, accept, trigger, slice_clr;
  logic [DATA_COUNT-1:0][DATA_WIDTH-1:0]  win_q, slice_d;

  // A held, untaken window stalls input so its contents stay stable.
  assign sample_ready = !flush && !(window_valid && !window_ready);
  assign accept       = sample_valid && sample_ready;
  assign slice_clr    = reset || flush;
  assign window_data  = win_q;

  for (genvar i = 0; i < DATA_COUNT; i++) begin : g_slice
    if (i == 0) begin : g_head
      assign slice_d[i] = sample_data;
    end else begin : g_body
      assign slice_d[i] = win_q[i-1];
    end
    window_slice #(.W(DATA_WIDTH)) u_slice (
      .clk  (clock50MHz),
      .clr  (slice_clr),
      .load (accept),
      .d    (slice_d[i]),
      .q    (win_q[i])
    );
  end

  always_comb begin
    state_nxt  = state;
    fill_nxt   = fill_count;
    stride_nxt = stride_cnt;
    trigger    = 1'b0;
    valid_nxt  = window_valid;
    if (window_valid && window_ready) valid_nxt = 1'b0;
    case (state)
      FILL: if (accept) begin
        fill_nxt = fill_count + FCW'(1);
        if (fill_count == FCW'(DATA_COUNT-1)) begin
          state_nxt  = STREAM;
          stride_nxt = '0;
          trigger    = 1'b1;
        end
      end
      STREAM: if (accept) begin
        if (stride_cnt == SCW'(STRIDE-1)) begin
          trigger    = 1'b1;
          stride_nxt = '0;
        end else begin
          stride_nxt = stride_cnt + SCW'(1);
        end
      end
    endcase
    if (trigger) valid_nxt = 1'b1;
    if (flush) begin
      state_nxt  = FILL;
      fill_nxt   = '0;
      stride_nxt = '0;
      valid_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clock50MHz) begin
    if (reset) begin
      state        <= FILL;
      fill_count   <= '0;
      stride_cnt   <= '0;
      window_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      fill_count   <= fill_nxt;
      stride_cnt   <= stride_nxt;
      window_valid <= valid_nxt;
    end
  end
endmodule

// One buffer slice: cleared on reset/flush, loads its neighbour on accept.
module window_slice #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (clr)       q <= '0;
    else if (load) q <= d;
  end
endmodule

// File: tb/tb_window_collector.sv
// Bench for window_collector: STRIDE=2 and STRIDE=1 instances share stimulus and
// are checked every cycle against a sample-history reference model.
module tb_window_collector;
  localparam int DC = 4;
  localparam int DW = 12;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic                  reset, flush, sample_valid, window_ready;
  logic [DW-1:0]         sample_data;
  logic [1:0]            sready, wvalid;
  logic [1:0][DC*DW-1:0] wdata;
  logic [1:0][2:0]       fcnt;

  window_collector #(.DATA_COUNT(DC), .DATA_WIDTH(DW), .STRIDE(2)) u_s2 (
    .clock50MHz(clk), .reset(reset), .sample_valid(sample_valid),
    .sample_data(sample_data), .sample_ready(sready[0]), .flush(flush),
    .window_valid(wvalid[0]), .window_ready(window_ready),
    .window_data(wdata[0]), .fill_count(fcnt[0]));

  window_collector #(.DATA_COUNT(DC), .DATA_WIDTH(DW), .STRIDE(1)) u_s1 (
    .clock50MHz(clk), .reset(reset), .sample_valid(sample_valid),
    .sample_data(sample_data), .sample_ready(sready[1]), .flush(flush),
    .window_valid(wvalid[1]), .window_ready(window_ready),
    .window_data(wdata[1]), .fill_count(fcnt[1]));

  int n_chk = 0, n_fail = 0;

  // Reference: every accepted sample since the last clear, in arrival order.
  logic [DW-1:0] hist [2][8192];
  int            n_acc [2] = '{0, 0};
  logic          m_valid [2] = '{1'b0, 1'b0};
  logic          m_rdy [2];
  int            strd [2] = '{2, 1};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DC*DW-1:0] model_win(input int k);
    logic [DC*DW-1:0] w = '0;
    for (int j = 0; j < DC; j++) begin
      int idx = n_acc[k] - 1 - j;
      if (idx >= 0) w[j*DW +: DW] = hist[k][idx];
    end
    return w;
  endfunction

  task automatic cyc(input logic r, input logic f, input logic sv,
                     input logic [DW-1:0] sd, input logic wr);
    reset = r; flush = f; sample_valid = sv; sample_data = sd; window_ready = wr;
    #1;
    for (int k = 0; k < 2; k++) begin
      m_rdy[k] = !f && !(m_valid[k] && !wr);
      if (!r) chk($sformatf("ready%0d", k), 64'(sready[k]), 64'(m_rdy[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r || f) begin
        n_acc[k] = 0;
        m_valid[k] = 1'b0;
      end else begin
        logic trig = 1'b0;
        logic xfer = m_valid[k] && wr;
        if (sv && m_rdy[k]) begin
          hist[k][n_acc[k]] = sd;
          n_acc[k]++;
          trig = (n_acc[k] == DC) || (n_acc[k] > DC && (n_acc[k] - DC) % strd[k] == 0);
        end
        if (trig) m_valid[k] = 1'b1;
        else if (xfer) m_valid[k] = 1'b0;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      int fc = (n_acc[k] > DC) ? DC : n_acc[k];
      chk($sformatf("wvalid%0d", k), 64'(wvalid[k]), 64'(m_valid[k]));
      chk($sformatf("wdata%0d", k), 64'(wdata[k]), 64'(model_win(k)));
      chk($sformatf("fill%0d", k), 64'(fcnt[k]), 64'(fc));
    end
  endtask

  initial begin
    cyc(1, 0, 1, 12'h0ff, 1);
    cyc(1, 0, 1, 12'h0ff, 1);
    chk("rst_wdata", 64'(wdata[0]), 64'h0);
    chk("rst_fill", 64'(fcnt[0]), 64'h0);
    chk("rst_valid", 64'(wvalid[0]), 64'h0);
    for (int i = 1; i <= 4; i++) cyc(0, 0, 1, 12'(i), 1);
    chk("win4_valid", 64'(wvalid[0]), 64'h1);
    chk("win4_data", 64'(wdata[0]), 64'h001002003004);
    chk("win4_fill", 64'(fcnt[0]), 64'h4);
    cyc(0, 0, 1, 12'h005, 1);
    chk("s2_no_win5", 64'(wvalid[0]), 64'h0);
    chk("s1_xfer_trig_valid", 64'(wvalid[1]), 64'h1);
    chk("s1_xfer_trig_data", 64'(wdata[1]), 64'h002003004005);
    cyc(0, 0, 1, 12'h006, 1);
    chk("win6_valid", 64'(wvalid[0]), 64'h1);
    chk("win6_data", 64'(wdata[0]), 64'h003004005006);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 12'h007, 0);
      chk("hold_data", 64'(wdata[0]), 64'h003004005006);
    end
    cyc(0, 0, 1, 12'h007, 1);
    chk("release_valid", 64'(wvalid[0]), 64'h0);
    chk("release_data", 64'(wdata[0]), 64'h004005006007);
    cyc(0, 0, 1, 12'h008, 1);
    cyc(0, 1, 1, 12'h009, 1);
    chk("flush_fill", 64'(fcnt[0]), 64'h0);
    chk("flush_valid", 64'(wvalid[0]), 64'h0);
    chk("flush_data", 64'(wdata[0]), 64'h0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 12'(12'h00a + i), 1);
    chk("refill_data", 64'(wdata[0]), 64'h00a00b00c00d);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
          $urandom_range(0, 3) != 0, 12'($urandom), $urandom_range(0, 2) != 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
